vrb_reduce_ctrl: RTL and testbench

VRB_REDUCE_CTRL -- requirements
Module: vrb_reduce_ctrl

---
 rtl/vrb_reduce_ctrl.sv | 123 ++++++++++++
 tb/tb_vrb_reduce_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vrb_reduce_ctrl.sv
// ============================================================================
// Module   : vrb_reduce_ctrl
// Brief    : Sequences vector-register-bank reads and sums vl elements into a
//            single reduction result, pulsing VRB_done to release decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vrb_reduce_ctrl #(
    parameter int DW = 32,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [6:0]    opcode,
    input  logic [IW-1:0] vl,
    output logic          vrb_rd_en,
    output logic [IW-1:0] vrb_rd_idx,
    input  logic [DW-1:0] vrb_rd_data,
    output logic [DW-1:0] result,
    output logic          VRB_done
);

    localparam logic [6:0]    c_op_reduce = 7'b1111111;
    localparam logic [IW-1:0] c_one       = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state,  w_state_nxt;
    logic [IW-1:0] r_vl,     w_vl_nxt;
    logic [IW-1:0] r_idx,    w_idx_nxt;
    logic [DW-1:0] r_acc,    w_acc_nxt;
    logic [DW-1:0] r_result, w_result_nxt;
    logic          r_rd_en,  w_rd_en_nxt;
    logic [IW-1:0] r_rd_idx, w_rd_idx_nxt;
    logic          r_done,   w_done_nxt;
    logic          r_rd_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vl     <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_rd_en  <= 1'b0;
            r_rd_idx <= '0;
            r_done   <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vl     <= w_vl_nxt;
            r_idx    <= w_idx_nxt;
            r_acc    <= w_acc_nxt;
            r_result <= w_result_nxt;
            r_rd_en  <= w_rd_en_nxt;
            r_rd_idx <= w_rd_idx_nxt;
            r_done   <= w_done_nxt;
            r_rd_vld <= r_rd_en;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt  = r_state;
        w_vl_nxt     = r_vl;
        w_idx_nxt    = r_idx;
        w_acc_nxt    = r_rd_vld ? (r_acc + vrb_rd_data) : r_acc;
        w_result_nxt = r_result;
        w_rd_en_nxt  = 1'b0;
        w_rd_idx_nxt = '0;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (opcode == c_op_reduce) begin
                    w_vl_nxt     = vl;
                    w_idx_nxt    = '0;
                    w_acc_nxt    = '0;
                    w_result_nxt = '0;
                    if (vl != '0) begin
                        w_state_nxt = READ;
                        w_rd_en_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            READ: begin
                w_idx_nxt = r_idx + c_one;
                if (r_idx == (r_vl - c_one)) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_rd_en_nxt  = 1'b1;
                    w_rd_idx_nxt = r_idx + c_one;
                end
            end
            DRAIN: begin
                // The last element lands this cycle; capture the completed sum.
                w_state_nxt  = DONE;
                w_done_nxt   = 1'b1;
                w_result_nxt = w_acc_nxt;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign vrb_rd_en  = r_rd_en;
    assign vrb_rd_idx = r_rd_idx;
    assign result     = r_result;
    assign VRB_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_vrb_reduce_ctrl.sv
// ============================================================================
// Module   : tb_vrb_reduce_ctrl
// Brief    : Directed self-checking bench for vrb_reduce_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vrb_reduce_ctrl;

    localparam int DW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [IW-1:0] vl;
    logic          vrb_rd_en;
    logic [IW-1:0] vrb_rd_idx;
    logic [DW-1:0] vrb_rd_data;
    logic [DW-1:0] result;
    logic          VRB_done;

    logic [DW-1:0] mem [0:31];
    int n_checks = 0;
    int n_errors = 0;

    vrb_reduce_ctrl #(.DW(DW), .IW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .vl          (vl),
        .vrb_rd_en   (vrb_rd_en),
        .vrb_rd_idx  (vrb_rd_idx),
        .vrb_rd_data (vrb_rd_data),
        .result      (result),
        .VRB_done    (VRB_done)
    );

    always #5 clk = ~clk;

    // Register-bank model: data one cycle after the strobe, poison otherwise.
    always @(posedge clk)
        vrb_rd_data <= vrb_rd_en ? mem[vrb_rd_idx] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a reduction and follow it to completion. With chain set, opcode is
    // left at the reduce value and vl switches to next_vl at the done cycle.
    task automatic run_red(input int n_el, input logic [31:0] exp_res, input bit chain,
                           input logic [IW-1:0] next_vl, input int chg_at,
                           input logic [IW-1:0] chg_vl);
        int exp_idx = 0;
        int lat     = 0;
        int bad_idx = 0;
        bit got     = 0;
        opcode = 7'b1111111;
        vl     = n_el[IW-1:0];
        for (int n = 1; n <= 60 && !got; n++) begin
            @(negedge clk);
            if (n == chg_at) vl = chg_vl;
            if (vrb_rd_en) begin
                check("rd_idx", 32'(vrb_rd_idx), 32'(exp_idx));
                exp_idx++;
            end else if (vrb_rd_idx != '0) begin
                bad_idx++;
            end
            if (VRB_done) begin
                got = 1;
                lat = n;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), (n_el == 0) ? 32'd1 : 32'(n_el + 2));
        check("result", result, exp_res);
        check("n_reads", 32'(exp_idx), 32'(n_el));
        check("idx_idle_zero", 32'(bad_idx), 32'd0);
        if (chain) vl = next_vl;
        else       opcode = 7'b0000000;
        @(negedge clk);
        check("done_one_cycle", 32'(VRB_done), 32'd0);
        check("result_hold", result, exp_res);
    endtask

    initial begin
        int cnt_en;
        int cnt_done;
        rst_n  = 1'b0;
        opcode = 7'b0000000;
        vl     = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
        repeat (3) @(negedge clk);
        check("rst_rd_en", 32'(vrb_rd_en), 32'd0);
        check("rst_rd_idx", 32'(vrb_rd_idx), 32'd0);
        check("rst_done", 32'(VRB_done), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // vl=4, data 1..4
        run_red(4, 32'd10, 0, '0, 0, '0);

        // vl=0: no reads, done after one cycle, result cleared
        run_red(0, 32'd0, 0, '0, 0, '0);

        // Wrap-around of the accumulator
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0002;
        run_red(2, 32'h0000_0001, 0, '0, 0, '0);

        // Reset during the third READ cycle
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
        opcode = 7'b1111111;
        vl     = 5'd8;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rd_en", 32'(vrb_rd_en), 32'd0);
        check("abort_rd_idx", 32'(vrb_rd_idx), 32'd0);
        check("abort_done", 32'(VRB_done), 32'd0);
        check("abort_result", result, 32'd0);
        rst_n  = 1'b1;
        opcode = 7'b0000000;
        cnt_en = 0; cnt_done = 0;
        repeat (12) begin
            @(negedge clk);
            cnt_en   += int'(vrb_rd_en);
            cnt_done += int'(VRB_done);
        end
        check("post_abort_quiet_en", 32'(cnt_en), 32'd0);
        check("post_abort_quiet_done", 32'(cnt_done), 32'd0);
        mem[0] = 32'd7;
        run_red(1, 32'd7, 0, '0, 0, '0);

        // Back-to-back reductions: vl=3 then vl=1
        mem[0] = 32'd5; mem[1] = 32'd6; mem[2] = 32'd7;
        run_red(3, 32'd18, 1, 5'd1, 0, '0);
        run_red(1, 32'd5, 0, '0, 0, '0);

        // Non-reduce opcode never starts
        opcode = 7'b0000000;
        vl     = 5'd3;
        cnt_en = 0; cnt_done = 0;
        repeat (6) begin
            @(negedge clk);
            cnt_en   += int'(vrb_rd_en);
            cnt_done += int'(VRB_done);
        end
        check("noop_rd_en", 32'(cnt_en), 32'd0);
        check("noop_done", 32'(cnt_done), 32'd0);

        // vl changed mid-READ: latched vl=5 still governs
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
        run_red(5, 32'd15, 0, '0, 2, 5'd2);

        // Maximum length: idx 0..30, sum 1..31
        run_red(31, 32'd496, 0, '0, 0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
